multi_cycle_control_unit: RTL and testbench

- Multi-cycle successor to the single-cycle control unit.
- A Moore FSM sequences each RV32I instruction through fetch, decode, execute, memory and writeback over 3–5 cycles, so the datapath can share one ALU and one memory port.
- Adds a memory ready handshake, a bounded wait timeout, and a sticky trap state for illegal opcodes and bus timeouts.
- Sits between the instruction register or flags and the shared datapath; its ALU-decode logic is parametrised in control width.

---
 rtl/yu_ctrl_pkg.sv | 81 ++++++++
 rtl/multi_cycle_alu_decoder.sv | 47 ++++
 rtl/multi_cycle_control_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yu_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit.
//   - state_t        : FSM state encoding (also exported on the debug port)
//   - OP_*           : RV32I major opcodes recognised by the decoder
//   - ALUOP_* / ALUC_*: ALU operation class and ALU control codes
//   - IMM_*, SRCA_*, SRCB_*, RES_* : datapath select codes
//   - TRAP_*         : trap cause codes
//   - imm_src_of()   : opcode -> immediate format
package yu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // Kept at 4 bits; the decoder resizes to the configured control width.
  localparam logic [3:0] ALUC_ADD  = 4'b0000;
  localparam logic [3:0] ALUC_SUB  = 4'b0001;
  localparam logic [3:0] ALUC_AND  = 4'b0010;
  localparam logic [3:0] ALUC_OR   = 4'b0011;
  localparam logic [3:0] ALUC_SLT  = 4'b0101;
  localparam logic [3:0] ALUC_SLTU = 4'b0110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] imm;
    imm = IMM_I;
    case (op)
      OP_STORE:         imm = IMM_S;
      OP_BRANCH:        imm = IMM_B;
      OP_JAL:           imm = IMM_J;
      OP_LUI, OP_AUIPC: imm = IMM_U;
      default:          imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multi_cycle_alu_decoder.sv
// Combinational ALU decoder: ALUOp/funct3/funct7b5 -> ALUControl.
// Ports:
//   alu_op      in  2           00 add, 01 sub, 10 decode from funct fields
//   funct3      in  3           instruction funct3
//   op5         in  1           opcode bit 5 (distinguishes R-type from I-type)
//   funct7b5    in  1           instruction bit 30
//   alu_control out ALU_CTRL_W  ALU operation code (zero-extended / resized)
// Macro BRANCH_EXT_EN adds sltu (funct3 011).
module multi_cycle_alu_decoder
  import yu_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [1:0]            alu_op,
  input  logic [2:0]            funct3,
  input  logic                  op5,
  input  logic                  funct7b5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic [3:0] code;

  always_comb begin
    code = ALUC_ADD;
    case (alu_op)
      ALUOP_ADD: code = ALUC_ADD;
      ALUOP_SUB: code = ALUC_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          // addi has op5 = 0, so a set bit 30 in its immediate never selects sub.
          3'b000:  code = (op5 && funct7b5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  code = ALUC_SLT;
`ifdef BRANCH_EXT_EN
          3'b011:  code = ALUC_SLTU;
`endif
          3'b110:  code = ALUC_OR;
          3'b111:  code = ALUC_AND;
          default: code = ALUC_ADD;
        endcase
      end
      default: code = ALUC_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control unit. A Moore FSM walks each instruction through
// fetch/decode/execute/memory/writeback so one ALU and one memory port can be
// shared. Illegal opcodes and memory timeouts enter a sticky TRAP state that
// only reset leaves.
// Ports:
//   clk, reset (async, active high)
//   opcode, funct3, funct7b5 : instruction fields
//   zero (+ negative, carry with BRANCH_EXT_EN) : ALU flags
//   memReady : memory completes the current access this cycle
//   PCWrite, adrSrc, memRead, memWrite, IRWrite, resultSrc, ALUSrcA, ALUSrcB,
//   immSrc, ALUControl, regWrite : datapath controls
//   trap, trapCause : sticky fault flag and cause
//   dbg_state : current FSM state
// Macro BRANCH_EXT_EN: full conditional-branch set plus sltu (ALU_CTRL_W = 4).
//
// Memory handshake: memRead/memWrite are a request held high for every cycle
// the FSM sits in FETCH/MEMREAD/MEMWRITE; the access completes in the cycle
// memReady is sampled high, and the FSM leaves the state at that edge. If the
// request has waited MEM_TIMEOUT cycles and memReady is still low in the next
// one, the FSM traps; memReady in that same cycle still completes normally.
module multi_cycle_control_unit
  import yu_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  memReady,
`ifdef BRANCH_EXT_EN
  input  logic                  negative,
  input  logic                  carry,
`endif
  output logic                  PCWrite,
  output logic                  adrSrc,
  output logic                  memRead,
  output logic                  memWrite,
  output logic                  IRWrite,
  output logic [1:0]            resultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            immSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  regWrite,
  output logic                  trap,
  output logic [1:0]            trapCause,
  output state_t                dbg_state
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  state_t           state;
  state_t           decode_next;
  state_t           mem_done_next;
  logic [TMO_W-1:0] wait_cnt;
  logic [1:0]       trap_cause_q;
  logic             branch_ok;
  logic             taken;

  logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] result_src, src_a, src_b, alu_op;

  // Branch funct3 values the unit can execute.
  always_comb begin
`ifdef BRANCH_EXT_EN
    branch_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
`else
    branch_ok = (funct3 == 3'b000);
`endif
  end

  always_comb begin
`ifdef BRANCH_EXT_EN
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = negative;
      3'b101:  taken = !negative;
      3'b110:  taken = !carry;
      3'b111:  taken = carry;
      default: taken = 1'b0;
    endcase
`else
    // Only beq reaches BRANCH in this build.
    taken = zero;
`endif
  end

  always_comb begin
    decode_next = S_TRAP;
    case (opcode)
      OP_LOAD, OP_STORE: decode_next = S_MEMADR;
      OP_RTYPE:          decode_next = S_EXECR;
      OP_ITYPE:          decode_next = S_EXECI;
      OP_BRANCH:         decode_next = branch_ok ? S_BRANCH : S_TRAP;
      OP_JAL:            decode_next = S_JAL;
      default:           decode_next = S_TRAP;
    endcase
  end

  always_comb begin
    case (state)
      S_FETCH:   mem_done_next = S_DECODE;
      S_MEMREAD: mem_done_next = S_MEMWB;
      default:   mem_done_next = S_FETCH;
    endcase
  end

  // State, wait counter and trap cause. The counter is cleared on every
  // cycle that does not extend a memory wait, which covers every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_FETCH;
      wait_cnt     <= '0;
      trap_cause_q <= TRAP_NONE;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_FETCH, S_MEMREAD, S_MEMWRITE: begin
          if (memReady) begin
            state <= mem_done_next;
          end else if (wait_cnt == TMO_LIMIT) begin
            state        <= S_TRAP;
            trap_cause_q <= TRAP_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
        end
        S_DECODE: begin
          state <= decode_next;
          if (decode_next == S_TRAP) trap_cause_q <= TRAP_ILLEGAL;
        end
        S_MEMADR:                   state <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMWB, S_ALUWB, S_BRANCH: state <= S_FETCH;
        S_EXECR, S_EXECI, S_JAL:    state <= S_ALUWB;
        S_TRAP:                     state <= S_TRAP;
        default:                    state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; only IRWrite/PCWrite in FETCH and PCWrite in BRANCH
  // look at live inputs.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        src_b      = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = memReady;
        pc_write   = memReady;
      end
      S_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        src_a = SRCA_RS1;
        src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        src_a  = SRCA_RS1;
        src_b  = SRCB_RS2;
        alu_op = ALUOP_FUNC;
      end
      S_EXECI: begin
        src_a  = SRCA_RS1;
        src_b  = SRCB_IMM;
        alu_op = ALUOP_FUNC;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        src_a    = SRCA_RS1;
        src_b    = SRCB_RS2;
        alu_op   = ALUOP_SUB;
        pc_write = taken;
      end
      S_JAL: begin
        src_a    = SRCA_OLDPC;
        src_b    = SRCB_FOUR;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  multi_cycle_alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (opcode[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  // Enables are masked by reset directly so nothing can write while reset
  // is high, independent of the state register.
  assign PCWrite   = pc_write  & ~reset;
  assign memRead   = mem_read  & ~reset;
  assign memWrite  = mem_write & ~reset;
  assign IRWrite   = ir_write  & ~reset;
  assign regWrite  = reg_write & ~reset;
  assign adrSrc    = adr_src;
  assign resultSrc = result_src;
  assign ALUSrcA   = src_a;
  assign ALUSrcB   = src_b;
  assign immSrc    = imm_src_of(opcode);
  assign trap      = (state == S_TRAP);
  assign trapCause = trap_cause_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
module tb_multi_cycle_control_unit;
  import yu_ctrl_pkg::*;

  localparam int TMO = 15;
`ifdef BRANCH_EXT_EN
  localparam int ALUW = 4;
`else
  localparam int ALUW = 3;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, zero = 1'b0, memReady = 1'b0;
  logic neg_v = 1'b0, car_v = 1'b0;
  logic PCWrite, adrSrc, memRead, memWrite, IRWrite, regWrite, trap;
  logic [1:0] resultSrc, ALUSrcA, ALUSrcB, trapCause;
  logic [2:0] immSrc;
  logic [ALUW-1:0] ALUControl;
  state_t dbg_state;

  always #5 clk = ~clk;

  multi_cycle_control_unit #(.ALU_CTRL_W(ALUW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .memReady(memReady),
`ifdef BRANCH_EXT_EN
    .negative(neg_v), .carry(car_v),
`endif
    .PCWrite(PCWrite), .adrSrc(adrSrc), .memRead(memRead), .memWrite(memWrite),
    .IRWrite(IRWrite), .resultSrc(resultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .immSrc(immSrc), .ALUControl(ALUControl),
    .regWrite(regWrite), .trap(trap), .trapCause(trapCause),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] st;
    logic pcw, adr, mrd, mwr, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [ALUW-1:0] alu;
    logic [2:0] imm;
    logic trp;
    logic [1:0] cause;
  } obs_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic f7;
    logic zr;
    int wf;               // memReady-low cycles in FETCH
    int wm;               // memReady-low cycles in MEMREAD/MEMWRITE
    logic [1:0] exp_cause; // expected trapCause at the end (00 = back in FETCH)
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_cause = 2'b00;
  state_t ph_q[$];

  function automatic logic [3:0] ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (op[5] && f7) ? 4'd1 : 4'd0;
      3'd2: return 4'd5;
`ifdef BRANCH_EXT_EN
      3'd3: return 4'd6;
`endif
      3'd6: return 4'd3;
      3'd7: return 4'd2;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic ref_branch_legal(input logic [2:0] f3);
`ifdef BRANCH_EXT_EN
    return !(f3 == 3'd2 || f3 == 3'd3);
`else
    return f3 == 3'd0;
`endif
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic zr, input logic ng, input logic cy);
    case (f3)
      3'd0: return zr;
      3'd1: return !zr;
      3'd4: return ng;
      3'd5: return !ng;
      3'd6: return !cy;
      3'd7: return cy;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] ref_imm(input logic [6:0] op);
    if (op == 7'b0100011) return 3'd1;
    if (op == 7'b1100011) return 3'd2;
    if (op == 7'b1101111) return 3'd4;
    if (op == 7'b0110111 || op == 7'b0010111) return 3'd3;
    return 3'd0;
  endfunction

  // Phase list an instruction walks through; illegal ones stop after DECODE.
  function automatic logic plan(input logic [6:0] op, input logic [2:0] f3);
    logic illegal;
    illegal = 1'b0;
    ph_q.delete();
    ph_q.push_back(S_FETCH);
    ph_q.push_back(S_DECODE);
    case (op)
      7'b0000011: begin ph_q.push_back(S_MEMADR); ph_q.push_back(S_MEMREAD); ph_q.push_back(S_MEMWB); end
      7'b0100011: begin ph_q.push_back(S_MEMADR); ph_q.push_back(S_MEMWRITE); end
      7'b0110011: begin ph_q.push_back(S_EXECR); ph_q.push_back(S_ALUWB); end
      7'b0010011: begin ph_q.push_back(S_EXECI); ph_q.push_back(S_ALUWB); end
      7'b1101111: begin ph_q.push_back(S_JAL); ph_q.push_back(S_ALUWB); end
      7'b1100011: if (ref_branch_legal(f3)) ph_q.push_back(S_BRANCH); else illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
    return illegal;
  endfunction

  function automatic void expect_phase(input state_t ph, input logic mr, output obs_t v, output obs_t m);
    v = '0; m = '0;
    m.st = '1; v.st = ph;
    m.pcw = 1; m.mrd = 1; m.mwr = 1; m.irw = 1; m.rw = 1;
    m.imm = '1; v.imm = ref_imm(opcode);
    m.trp = 1; v.trp = (ph == S_TRAP);
    m.cause = '1; v.cause = exp_cause;
    case (ph)
      S_FETCH: begin
        v.mrd = 1; m.adr = 1; v.adr = 0;
        m.sa = '1; v.sa = 2'b00; m.sb = '1; v.sb = 2'b10;
        m.rs = '1; v.rs = 2'b10; m.alu = '1; v.alu = '0;
        v.irw = mr; v.pcw = mr;
      end
      S_DECODE: begin m.sa = '1; v.sa = 2'b01; m.sb = '1; v.sb = 2'b01; m.alu = '1; v.alu = '0; end
      S_MEMADR: begin m.sa = '1; v.sa = 2'b10; m.sb = '1; v.sb = 2'b01; m.alu = '1; v.alu = '0; end
      S_MEMREAD: begin v.mrd = 1; m.adr = 1; v.adr = 1; end
      S_MEMWB: begin m.rs = '1; v.rs = 2'b01; v.rw = 1; end
      S_MEMWRITE: begin v.mwr = 1; m.adr = 1; v.adr = 1; end
      S_EXECR, S_EXECI: begin
        m.sa = '1; v.sa = 2'b10; m.sb = '1; v.sb = (ph == S_EXECR) ? 2'b00 : 2'b01;
        m.alu = '1; v.alu = ALUW'(ref_alu(opcode, funct3, funct7b5));
      end
      S_ALUWB: begin m.rs = '1; v.rs = 2'b00; v.rw = 1; end
      S_BRANCH: begin
        m.sa = '1; v.sa = 2'b10; m.sb = '1; v.sb = 2'b00; m.rs = '1; v.rs = 2'b00;
        m.alu = '1; v.alu = ALUW'(1);
        v.pcw = ref_taken(funct3, zero, neg_v, car_v);
      end
      S_JAL: begin
        m.sa = '1; v.sa = 2'b01; m.sb = '1; v.sb = 2'b10; m.rs = '1; v.rs = 2'b00;
        m.alu = '1; v.alu = '0; v.pcw = 1;
      end
      default: ;
    endcase
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.st = dbg_state; o.pcw = PCWrite; o.adr = adrSrc; o.mrd = memRead;
    o.mwr = memWrite; o.irw = IRWrite; o.rw = regWrite; o.rs = resultSrc;
    o.sa = ALUSrcA; o.sb = ALUSrcB; o.alu = ALUControl; o.imm = immSrc;
    o.trp = trap; o.cause = trapCause;
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic compare(input string name, input obs_t v, input obs_t m);
    obs_t o;
    o = observe();
    checks++;
    if (((o ^ v) & m) !== '0) begin
      errors++;
      $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, o, v, m, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_now(input state_t ph, input logic mr);
    obs_t v, m;
    memReady = mr;
    #1;
    expect_phase(ph, mr, v, m);
    compare(ph.name(), v, m);
  endtask

  task automatic check_cycle(input state_t ph, input logic mr);
    check_now(ph, mr);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    obs_t v, m;
    memReady = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    v = '0; m = '0;
    v.st = S_FETCH; m.st = '1;
    m.pcw = 1; m.mrd = 1; m.mwr = 1; m.irw = 1; m.rw = 1; m.trp = 1; m.cause = '1;
    compare("reset", v, m);
    @(posedge clk);
    #1;
    compare("reset_hold", v, m);
    #2;
    reset = 1'b0;
    exp_cause = 2'b00;
  endtask

  task automatic run_instr(input vec_t t, output logic [1:0] cause);
    logic illegal, mr;
    int nlow;
    state_t ph;
    opcode = t.op; funct3 = t.f3; funct7b5 = t.f7; zero = t.zr;
    cause = 2'b00;
    illegal = plan(t.op, t.f3);
    for (int p = 0; p < ph_q.size() && cause == 2'b00; p++) begin
      ph = ph_q[p];
      if (ph == S_FETCH || ph == S_MEMREAD || ph == S_MEMWRITE) begin
        nlow = (ph == S_FETCH) ? t.wf : t.wm;
        for (int k = 0; k <= TMO; k++) begin
          mr = (k >= nlow);
          check_cycle(ph, mr);
          if (mr) break;
          if (k == TMO) cause = 2'b10;
        end
      end else begin
        check_cycle(ph, 1'($urandom_range(0, 1)));
      end
    end
    if (cause == 2'b00 && illegal) cause = 2'b01;
    if (cause != 2'b00) exp_cause = cause;
  endtask

  task automatic hold_trap_and_reset(input int n);
    for (int i = 0; i < n; i++) check_cycle(S_TRAP, 1'($urandom_range(0, 1)));
    apply_reset();
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t tbl[18];
    logic [1:0] cause;
    vec_t r;
    int sel;

    tbl[0]  = '{7'b0000011, 3'd2, 1'b0, 1'b0, 0, 0, 2'b00};  // lw
    tbl[1]  = '{7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0, 2'b00};  // add
    tbl[2]  = '{7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0, 2'b00};  // sub
    tbl[3]  = '{7'b0110011, 3'd7, 1'b0, 1'b0, 0, 0, 2'b00};  // and
    tbl[4]  = '{7'b0110011, 3'd6, 1'b0, 1'b0, 0, 0, 2'b00};  // or
    tbl[5]  = '{7'b0110011, 3'd2, 1'b0, 1'b0, 0, 0, 2'b00};  // slt
    tbl[6]  = '{7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0, 2'b00};  // addi, bit30 set
    tbl[7]  = '{7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0, 2'b00};  // beq taken
    tbl[8]  = '{7'b1100011, 3'd0, 1'b0, 1'b0, 0, 0, 2'b00};  // beq not taken
    tbl[9]  = '{7'b1101111, 3'd0, 1'b0, 1'b0, 0, 0, 2'b00};  // jal
    tbl[10] = '{7'b0100011, 3'd2, 1'b0, 1'b0, 0, 0, 2'b00};  // sw
    tbl[11] = '{7'b0000011, 3'd2, 1'b0, 1'b0, 3, 2, 2'b00};  // lw with waits
    tbl[12] = '{7'b0100011, 3'd2, 1'b0, 1'b0, 0, 15, 2'b00}; // sw, ready on limit cycle
    tbl[13] = '{7'b0100011, 3'd2, 1'b0, 1'b0, 0, 16, 2'b10}; // sw timeout
    tbl[14] = '{7'b0000000, 3'd0, 1'b0, 1'b0, 0, 0, 2'b01}; // illegal opcode
`ifdef BRANCH_EXT_EN
    tbl[15] = '{7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0, 2'b00}; // bne
`else
    tbl[15] = '{7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0, 2'b01}; // bne unsupported
`endif
    tbl[16] = '{7'b0000011, 3'd2, 1'b0, 1'b0, 16, 0, 2'b10}; // fetch timeout
    tbl[17] = '{7'b0110011, 3'd1, 1'b0, 1'b0, 0, 0, 2'b00};  // sll -> add

    @(posedge clk);
    #1;
    apply_reset();

    // Directed table
    for (int i = 0; i < 18; i++) begin
      run_instr(tbl[i], cause);
      exp_cause = tbl[i].exp_cause;
      check_now((tbl[i].exp_cause != 2'b00) ? S_TRAP : S_FETCH, 1'b0);
      if (tbl[i].exp_cause != 2'b00) begin
        @(posedge clk);
        #1;
        hold_trap_and_reset(20);
      end
    end

    // Reset in the middle of a load writeback
    opcode = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
    check_cycle(S_FETCH, 1'b1);
    check_cycle(S_DECODE, 1'b0);
    check_cycle(S_MEMADR, 1'b0);
    check_cycle(S_MEMREAD, 1'b1);
    check_now(S_MEMWB, 1'b0);
    apply_reset();

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      r.f3 = 3'($urandom_range(0, 7));
      r.f7 = 1'($urandom_range(0, 1));
      r.zr = 1'($urandom_range(0, 1));
      r.wf = ($urandom_range(0, 24) == 0) ? 16 : $urandom_range(0, 3);
      r.wm = ($urandom_range(0, 24) == 0) ? 16 : $urandom_range(0, 3);
      r.exp_cause = 2'b00;
      neg_v = 1'($urandom_range(0, 1));
      car_v = 1'($urandom_range(0, 1));
      case (sel)
        0: r.op = 7'b0000011;
        1: r.op = 7'b0100011;
        2, 3, 8: r.op = 7'b0110011;
        4, 9: r.op = 7'b0010011;
        5: begin r.op = 7'b1100011; if ($urandom_range(0, 1) == 0) r.f3 = 3'd0; end
        6: r.op = 7'b1101111;
        default: r.op = ($urandom_range(0, 1) == 0) ? 7'b0110111 : 7'($urandom_range(0, 127));
      endcase
      run_instr(r, cause);
      if (cause != 2'b00) hold_trap_and_reset(3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
